// File: rtl/cla_pkg.sv
// Shared constants and the expanded carry-lookahead equation used at both
// the bit level (inside each group) and the group level (in the top).
package cla_pkg;

    localparam int CLA_W    = 16;
    localparam int CLA_GRP  = 4;
    localparam int CLA_NGRP = CLA_W / CLA_GRP;

    // Carry into position idx as a flat sum of products:
    // g[idx-1] | p[idx-1]g[idx-2] | ... | p[idx-1]..p[0]ci.
    // Every term is formed independently, so nothing ripples.
    function automatic logic cla_carry(input logic [CLA_GRP-1:0] p,
                                       input logic [CLA_GRP-1:0] g,
                                       input logic               ci,
                                       input int                 idx);
        logic c;
        logic term;
        c = 1'b0;
        for (int j = 0; j < CLA_GRP; j++) begin
            if (j < idx) begin
                term = g[j];
                for (int k = 0; k < CLA_GRP; k++) begin
                    if (k > j && k < idx) term = term & p[k];
                end
                c = c | term;
            end
        end
        term = ci;
        for (int k = 0; k < CLA_GRP; k++) begin
            if (k < idx) term = term & p[k];
        end
        return c | term;
    endfunction

endpackage

// File: rtl/cla4_grp.sv
// 4-bit lookahead group: local sum plus group propagate/generate for the
// second-level lookahead unit.
module cla4_grp
    import cla_pkg::*;
(
    input  logic [CLA_GRP-1:0] a,
    input  logic [CLA_GRP-1:0] b,
    input  logic               ci,
    output logic [CLA_GRP-1:0] s,
    output logic               gp,
    output logic               gg
);

    logic [CLA_GRP-1:0] p;
    logic [CLA_GRP-1:0] g;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        s = '0;
        for (int i = 0; i < CLA_GRP; i++) begin
            s[i] = p[i] ^ cla_carry(p, g, ci, i);
        end
    end

    assign gp = &p;
    // Group generate is the carry-out assuming no carry-in.
    assign gg = cla_carry(p, g, 1'b0, CLA_GRP);

endmodule

// File: rtl/cla16.sv
// 16-bit two-level carry-lookahead adder with a single registered output stage.
module cla16
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             cin,
    output logic [CLA_W-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    logic [CLA_NGRP-1:0] grp_p;
    logic [CLA_NGRP-1:0] grp_g;
    logic [CLA_NGRP-1:0] grp_c;
    logic [CLA_W-1:0]    sum_d, sum_q;
    logic                cout_d, cout_q;
    logic                vld_q;

    // Second-level lookahead: C4/C8/C12 feed the groups, C16 is the carry-out.
    always_comb begin
        grp_c = '0;
        for (int k = 0; k < CLA_NGRP; k++) begin
            grp_c[k] = cla_carry(grp_p, grp_g, cin, k);
        end
        cout_d = cla_carry(grp_p, grp_g, cin, CLA_NGRP);
    end

    for (genvar k = 0; k < CLA_NGRP; k++) begin : g_grp
        cla4_grp u_grp (
            .a  (a[k*CLA_GRP +: CLA_GRP]),
            .b  (b[k*CLA_GRP +: CLA_GRP]),
            .ci (grp_c[k]),
            .s  (sum_d[k*CLA_GRP +: CLA_GRP]),
            .gp (grp_p[k]),
            .gg (grp_g[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_cla16.sv
// Self-checking bench for cla16: directed vector table, hold/reset sequences,
// and random back-to-back adds against a plain-arithmetic reference.
module tb_cla16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    cla16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
        return {1'b0, x} + {1'b0, y} + {16'd0, c};
    endfunction

    vec_t vecs[10];

    initial begin
        logic [16:0] exp_q;
        logic        have_prev;

        vecs[0] = '{16'd5000,  16'd990,   1'b0, 16'd5990,  1'b0};
        vecs[1] = '{16'd13332, 16'd1301,  1'b0, 16'd14633, 1'b0};
        vecs[2] = '{16'd0,     16'd0,     1'b0, 16'd0,     1'b0};
        vecs[3] = '{16'd32700, 16'd67,    1'b0, 16'd32767, 1'b0};
        vecs[4] = '{16'd5000,  16'd990,   1'b1, 16'd5991,  1'b0};
        vecs[5] = '{16'd13332, 16'd1301,  1'b1, 16'd14634, 1'b0};
        vecs[6] = '{16'd0,     16'd0,     1'b1, 16'd1,     1'b0};
        vecs[7] = '{16'd32700, 16'd67,    1'b1, 16'd32768, 1'b0};
        vecs[8] = '{16'hFFFF,  16'h0000,  1'b1, 16'h0000,  1'b1};
        vecs[9] = '{16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);

        // Operands presented during reset must not be captured.
        a = 16'd7; b = 16'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("reset_no_capture", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;

        // Directed table, each vector isolated so latency and out_valid are visible.
        foreach (vecs[i]) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
        end

        // Hold: load 5000+990 then idle three cycles with junk on the operands.
        @(negedge clk);
        a = 16'd5000; b = 16'd990; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 16'h1234; b = 16'h4321; cin = 1'b1;
        chk("hold_load", 32'(sum), 32'd5990);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_sum", i), 32'(sum), 32'd5990);
            chk($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd0);
        end

        // Asynchronous reset between edges with a live result.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sum", 32'(sum), 32'd0);
        chk("async_rst_cout", 32'(cout), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        a = 16'd1; b = 16'd2; cin = 1'b0; in_valid = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("first_capture_sum", 32'(sum), 32'd3);
        chk("first_capture_valid", 32'(out_valid), 32'd1);

        // Random back-to-back traffic, one add accepted every cycle.
        have_prev = 1'b0;
        exp_q = '0;
        for (int i = 0; i <= 10000; i++) begin
            @(negedge clk);
            if (have_prev) begin
                chk("rand_sum", 32'(sum), 32'(exp_q[15:0]));
                chk("rand_cout", 32'(cout), 32'(exp_q[16]));
                chk("rand_valid", 32'(out_valid), 32'd1);
            end
            if (i < 10000) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
                in_valid = 1'b1;
                exp_q = ref_add(a, b, cin);
                have_prev = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
